// File: rtl/ov7670_capture_pkg.sv
// Shared definitions for the OV7670 capture path and its downstream stages:
// FSM encoding, default frame geometry and RGB444 field widths.
package ov7670_capture_pkg;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_BLANK = 2'd1,
        ST_LINE  = 2'd2
    } cap_state_t;

    localparam int H_PIXELS_DEF = 640;
    localparam int V_LINES_DEF  = 480;

    localparam int RGB_CH_W = 4;
    localparam int RGB_W    = 3 * RGB_CH_W;

    localparam int X_W = 10;
    localparam int Y_W = 9;

endpackage

// File: rtl/ov7670_capture_byte_pair.sv
// Byte-phase tracker and RGB444 pixel assembler: phase 0 keeps the red nibble,
// phase 1 completes {R, G, B} combinationally from the incoming byte.
module rgb444_byte_pair
    import ov7670_capture_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [7:0]       i_dat,
    output logic             o_phase,
    output logic             o_vld,
    output logic [RGB_W-1:0] o_pix
);

    logic                r_phase;
    logic [RGB_CH_W-1:0] r_red;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_red   <= '0;
        end else if (i_clr) begin
            r_phase <= 1'b0;
        end else if (i_en) begin
            if (!r_phase) begin
                r_red <= i_dat[RGB_CH_W-1:0];
            end
            r_phase <= ~r_phase;
        end
    end

    assign o_phase = r_phase;
    assign o_vld   = i_en & r_phase;
    assign o_pix   = {r_red, i_dat};

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 frame capture: tracks VSYNC/HREF framing, emits registered RGB444
// pixels with column/row addresses and flags framing errors stickily.
module ov7670_capture
    import ov7670_capture_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_LINES  = V_LINES_DEF
) (
    input  logic             clk25,
    input  logic             resetN,
    input  logic             vsync,
    input  logic             href,
    input  logic [7:0]       dIn,
    output logic [RGB_W-1:0] pixelOut,
    output logic             pixelValid,
    output logic [X_W-1:0]   xAddr,
    output logic [Y_W-1:0]   yAddr,
    output logic             frameStart,
    output logic             frameDone,
    output logic             errSticky
);

    localparam logic [10:0] LP_H = 11'(H_PIXELS);
    localparam logic [9:0]  LP_V = 10'(V_LINES);

    cap_state_t       r_state;
    cap_state_t       w_state_nxt;
    logic             r_vsync_d;
    logic [10:0]      r_col;
    logic [9:0]       r_row;
    logic             r_line_emit;
    logic [RGB_W-1:0] r_pix;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic             r_vld;
    logic             r_fstart;
    logic             r_fdone;
    logic             r_err;

    logic             w_cap;
    logic             w_to_line;
    logic             w_to_sync;
    logic             w_line_end;
    logic             w_emit;
    logic             w_fstart;
    logic             w_err_new;
    logic             w_phase;
    logic             w_pix_vld;
    logic [RGB_W-1:0] w_pix;

    rgb444_byte_pair u_byte_pair (
        .clk     (clk25),
        .rst_n   (resetN),
        .i_en    (w_cap),
        .i_clr   (!w_cap),
        .i_dat   (dIn),
        .o_phase (w_phase),
        .o_vld   (w_pix_vld),
        .o_pix   (w_pix)
    );

    always_ff @(posedge clk25 or negedge resetN) begin
        if (!resetN) begin
            r_state   <= ST_SYNC;
            r_vsync_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vsync_d <= vsync;
        end
    end

    // SYNC only leaves on an observed 1->0 of vsync, so a reset mid-line waits a full frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SYNC:  if (r_vsync_d && !vsync) w_state_nxt = ST_BLANK;
            ST_BLANK: if (vsync) w_state_nxt = ST_SYNC;
                      else if (href) w_state_nxt = ST_LINE;
            ST_LINE:  if (vsync) w_state_nxt = ST_SYNC;
                      else if (!href) w_state_nxt = ST_BLANK;
            default:  w_state_nxt = ST_SYNC;
        endcase
    end

    always_comb begin
        w_cap      = !vsync && href && (r_state != ST_SYNC);
        w_to_line  = (r_state == ST_BLANK) && w_cap;
        w_to_sync  = vsync && (r_state != ST_SYNC);
        w_line_end = (r_state == ST_LINE) && !vsync && !href;
        w_emit     = w_pix_vld && (r_col < LP_H) && (r_row < LP_V);
        w_fstart   = w_to_line && (r_row == '0);
        w_err_new  = (w_pix_vld && !w_emit)
                   || (w_line_end && w_phase)
                   || ((r_state == ST_LINE) && vsync);
    end

    always_ff @(posedge clk25 or negedge resetN) begin
        if (!resetN) begin
            r_col       <= '0;
            r_row       <= '0;
            r_line_emit <= 1'b0;
            r_pix       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_vld       <= 1'b0;
            r_fstart    <= 1'b0;
            r_fdone     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_vld    <= w_emit;
            r_fstart <= w_fstart;
            r_fdone  <= w_to_sync;
            // Clearing on frameStart must not mask an error raised the same cycle.
            r_err    <= (r_err & !w_fstart) | w_err_new;
            if (w_emit) begin
                r_pix       <= w_pix;
                r_x         <= r_col[X_W-1:0];
                r_y         <= r_row[Y_W-1:0];
                r_line_emit <= 1'b1;
            end
            if (w_to_line) begin
                r_col       <= '0;
                r_line_emit <= 1'b0;
            end else if (w_pix_vld && (r_col < LP_H)) begin
                r_col <= r_col + 11'd1;
            end
            if (w_to_sync) begin
                r_row <= '0;
                r_y   <= '0;
            end else if (w_line_end && r_line_emit) begin
                r_row <= r_row + 10'd1;
            end
        end
    end

    assign pixelOut   = r_pix;
    assign pixelValid = r_vld;
    assign xAddr      = r_x;
    assign yAddr      = r_y;
    assign frameStart = r_fstart;
    assign frameDone  = r_fdone;
    assign errSticky  = r_err;

endmodule
